pwm_timebase: RTL and testbench
===============================

PWM_TIMEBASE -- requirements
Module: pwm_timebase

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4: clk cycles per counter step, legal range 1..256.
REQ-002 The block SHALL have parameter STEP, default 16: duty change per inc/dec pulse, legal range 1..1023.
REQ-003 The block SHALL have input clk, 1 bit: clock; all state changes on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have input en, 1 bit: high = timebase runs; low = prescaler and count hold.
REQ-006 The block SHALL have input inc, 1 bit: single-cycle pulse that raises the shadow duty by STEP.
REQ-007 The block SHALL have input dec, 1 bit: single-cycle pulse that lowers the shadow duty by STEP.
REQ-008 The block SHALL have output count, 10 bits: sawtooth counter value, driving the downstream comparator n2 input.
REQ-009 The block SHALL have output duty, 10 bits: active duty value, driving the downstream comparator n1 input.
REQ-010 The block SHALL have output wrap, 1 bit: one-cycle pulse marking the start of a PWM period.
REQ-011 The block SHALL have output duty_pending, 1 bit: high while the shadow duty differs from the active duty.

Function
REQ-012 The prescaler SHALL count 0..PRESCALE-1 while en=1 and issue a tick in the cycle it equals PRESCALE-1, then return to 0.
REQ-013 count SHALL increment by 1 on each tick and wrap from 1023 to 0; one PWM period = 1024*PRESCALE cycles.
REQ-014 wrap SHALL be high for exactly the one cycle in which count first shows 0 after a 1023->0 transition; it SHALL not fire after reset.
REQ-015 The shadow duty SHALL use 11-bit arithmetic: inc gives min(shadow+STEP, 1023); dec gives max(shadow-STEP, 0).
REQ-016 inc and dec asserted in the same cycle SHALL leave the shadow duty unchanged.
REQ-017 inc/dec SHALL update the shadow duty regardless of en.
REQ-018 duty SHALL load the shadow duty only on the clock edge where count goes 1023->0, never mid-period; an inc/dec in that same cycle is applied to the shadow only and reaches duty at the following wrap.
REQ-019 duty_pending SHALL be a combinational compare: shadow != duty.
REQ-020 With en=0, count, prescaler and duty SHALL hold, and wrap SHALL stay 0.
REQ-021 There SHALL be no inc/dec pulse synchronisation or debouncing inside the block; inputs are already clean and synchronous.

Reset
REQ-022 While reset=1, prescaler, count, shadow duty and duty SHALL be 0, and wrap SHALL be 0, on the next rising edge.
REQ-023 reset SHALL take priority over en, inc and dec, including mid-period; the first tick after release SHALL occur PRESCALE cycles after release.

Structure
REQ-024 Package pwm_pkg SHALL hold CNT_W=10 and CNT_MAX=1023, shared with the comparator.
REQ-025 The prescaler SHALL be the sub-module pwm_prescaler (inputs clk, reset, en; output tick); all other logic SHALL be in pwm_timebase.
REQ-026 All outputs except duty_pending SHALL be driven from registers.

Verification
REQ-027 PRESCALE=4, en=1 from reset: count SHALL reach 1 at cycle 4 and 1023 at cycle 4092, wrap SHALL be high at cycle 4096 only, and duty_pending SHALL stay 0 throughout.
REQ-028 3 inc pulses at count=100: shadow SHALL be 48 and duty_pending=1; duty SHALL stay 0 until the wrap edge, then become 48 with duty_pending=0.
REQ-029 Shadow 1020 + inc SHALL give 1023; shadow 10 + dec SHALL give 0; inc and dec together at shadow 500 SHALL leave 500.
REQ-030 Drop en at count=300 for 50 cycles: count SHALL hold 300, inc SHALL still change the shadow, duty SHALL be unchanged, and counting SHALL resume from 300.
REQ-031 Assert reset at count=700 with duty=512: all registers SHALL be 0 the next cycle, and no wrap SHALL fire.
REQ-032 PRESCALE=1: count SHALL step every cycle, and wrap SHALL pulse every 1024 cycles.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared constants and helpers for the PWM timebase and its downstream
//   comparator.
//   CNT_W / CNT_MAX : width and top value of the sawtooth counter.
//   cnt_t           : counter / duty value type.
//   shadow_next()   : saturating shadow-duty update for one inc/dec cycle.
package pwm_pkg;

    localparam int CNT_W     = 10;
    localparam int CNT_MAX   = 1023;
    localparam int DUTY_EXT_W = CNT_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // An 11-bit intermediate keeps both the overflow above CNT_MAX and the
    // borrow below zero visible, so the result can be clamped.
    function automatic cnt_t shadow_next(input cnt_t        cur,
                                         input logic        inc,
                                         input logic        dec,
                                         input int unsigned step);
        logic [DUTY_EXT_W-1:0] ext;
        logic [DUTY_EXT_W-1:0] sum;
        logic [DUTY_EXT_W-1:0] diff;
        cnt_t                  res;
        ext  = {1'b0, cur};
        sum  = ext + DUTY_EXT_W'(step);
        diff = ext - DUTY_EXT_W'(step);
        res  = cur;
        if (inc && !dec) begin
            if (sum > DUTY_EXT_W'(CNT_MAX)) begin
                res = cnt_t'(CNT_MAX);
            end else begin
                res = sum[CNT_W-1:0];
            end
        end else if (dec && !inc) begin
            // Top bit set means the subtraction borrowed.
            if (diff[DUTY_EXT_W-1]) begin
                res = '0;
            end else begin
                res = diff[CNT_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler
//   Divides clk by PRESCALE while en is high; tick is high in the cycle the
//   internal count sits at PRESCALE-1.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high reset
//     en    : run enable; low holds the count
//     tick  : one-cycle step strobe for the sawtooth counter
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // With PRESCALE=1, PS_LAST is 0 and the count never leaves 0, so tick
    // simply follows en.
    assign tick = en && (ps_q == PS_LAST);

    always_comb begin
        ps_d = ps_q;
        if (en) begin
            ps_d = tick ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/pwm_timebase.sv
// pwm_timebase
//   Sawtooth timebase for a PWM channel with a double-buffered duty value.
//   inc/dec adjust a shadow duty at any time; the active duty only takes the
//   shadow value at the 1023->0 rollover, so a period is never cut mid-way.
//   Ports:
//     clk          : clock, rising edge
//     reset        : synchronous, active-high reset
//     en           : run enable for prescaler and counter
//     inc / dec    : single-cycle shadow duty adjust pulses (+/- STEP)
//     count        : sawtooth counter value (registered)
//     duty         : active duty value (registered)
//     wrap         : one-cycle pulse while count first shows 0 (registered)
//     duty_pending : shadow duty differs from active duty (combinational)
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned STEP     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] duty,
    output logic             wrap,
    output logic             duty_pending
);

    logic tick;
    logic period_end;

    cnt_t count_q,  count_d;
    cnt_t shadow_q, shadow_d;
    cnt_t duty_q,   duty_d;
    logic wrap_q,   wrap_d;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    // tick already implies en, so nothing here moves while disabled.
    assign period_end = tick && (count_q == cnt_t'(CNT_MAX));

    always_comb begin
        count_d  = tick ? count_q + cnt_t'(1) : count_q;
        duty_d   = period_end ? shadow_q : duty_q;
        wrap_d   = period_end;
        // Applied every cycle regardless of en; a pulse on the rollover edge
        // lands in the shadow while duty takes the pre-pulse shadow value.
        shadow_d = shadow_next(shadow_q, inc, dec, STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            shadow_q <= '0;
            duty_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            shadow_q <= shadow_d;
            duty_q   <= duty_d;
            wrap_q   <= wrap_d;
        end
    end

    assign count        = count_q;
    assign duty         = duty_q;
    assign wrap         = wrap_q;
    assign duty_pending = (shadow_q != duty_q);

endmodule

// File: tb/tb_pwm_timebase.sv
module tb_pwm_timebase;

    logic       clk = 1'b0;
    logic       reset, en, inc, dec;
    logic [9:0] count, duty;
    logic       wrap, duty_pending;

    logic       f_reset, f_en, f_inc, f_dec;
    logic [9:0] f_count, f_duty;
    logic       f_wrap, f_pend;

    int n_pass = 0;
    int n_total = 0;
    int bad;

    always #5 clk = ~clk;

    pwm_timebase #(.PRESCALE(4), .STEP(16)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .inc          (inc),
        .dec          (dec),
        .count        (count),
        .duty         (duty),
        .wrap         (wrap),
        .duty_pending (duty_pending)
    );

    pwm_timebase #(.PRESCALE(1), .STEP(10)) u_fast (
        .clk          (clk),
        .reset        (f_reset),
        .en           (f_en),
        .inc          (f_inc),
        .dec          (f_dec),
        .count        (f_count),
        .duty         (f_duty),
        .wrap         (f_wrap),
        .duty_pending (f_pend)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            inc = i; dec = d;
            step(1);
            inc = 1'b0; dec = 1'b0;
            step(1);
        end
    endtask

    task automatic f_pulse(input logic i, input logic d, input int n);
        for (int k = 0; k < n; k++) begin
            f_inc = i; f_dec = d;
            step(1);
            f_inc = 1'b0; f_dec = 1'b0;
            step(1);
        end
    endtask

    task automatic wait_count(input int target, input string tag);
        int n;
        n = 0;
        while (count !== 10'(target) && n < 5000) begin
            step(1);
            n++;
        end
        chk(tag, 32'(count), 32'(target));
    endtask

    task automatic wait_wrap(input string tag);
        int n;
        n = 0;
        while (wrap !== 1'b1 && n < 16) begin
            step(1);
            n++;
        end
        chk(tag, 32'(wrap), 1);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; inc = 1'b1; dec = 1'b0;
        f_reset = 1'b1; f_en = 1'b0; f_inc = 1'b0; f_dec = 1'b0;
        step(3);
        inc = 1'b0;
        step(1);
        chk("rst_count", 32'(count), 0);
        chk("rst_duty", 32'(duty), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_pending", 32'(duty_pending), 0);
        chk("rst_shadow_inc_ignored", 32'(u_dut.shadow_q), 0);

        // First period from reset release.
        reset = 1'b0;
        bad = 0;
        for (int i = 1; i <= 4096; i++) begin
            step(1);
            if (i == 3)    chk("cnt_edge3", 32'(count), 0);
            if (i == 4)    chk("cnt_edge4", 32'(count), 1);
            if (i == 4092) chk("cnt_edge4092", 32'(count), 1023);
            if (i == 4095) chk("cnt_edge4095", 32'(count), 1023);
            if (i == 4096) begin
                chk("cnt_edge4096", 32'(count), 0);
                chk("wrap_edge4096", 32'(wrap), 1);
            end else if (wrap !== 1'b0) begin
                bad++;
            end
            if (duty_pending !== 1'b0) bad++;
        end
        chk("period1_no_stray_wrap_or_pending", 32'(bad), 0);
        step(1);
        chk("wrap_one_cycle", 32'(wrap), 0);

        // Shadow update mid-period, loaded at rollover.
        wait_count(100, "reach_100");
        pulse(1'b1, 1'b0, 3);
        chk("shadow_48", 32'(u_dut.shadow_q), 48);
        chk("pending_after_inc", 32'(duty_pending), 1);
        chk("duty_hold_mid", 32'(duty), 0);
        wait_count(1023, "reach_1023_a");
        chk("duty_hold_1023", 32'(duty), 0);
        wait_wrap("wrap_a");
        chk("duty_load_48", 32'(duty), 48);
        chk("pending_clear", 32'(duty_pending), 0);
        chk("cnt_at_wrap_a", 32'(count), 0);

        // Enable low holds counter but not shadow updates.
        wait_count(300, "reach_300");
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            inc = (i == 10);
            step(1);
            if (wrap !== 1'b0 || count !== 10'd300) bad++;
        end
        inc = 1'b0;
        chk("hold_no_move", 32'(bad), 0);
        chk("hold_count", 32'(count), 300);
        chk("hold_duty", 32'(duty), 48);
        chk("hold_shadow", 32'(u_dut.shadow_q), 64);
        chk("hold_pending", 32'(duty_pending), 1);
        en = 1'b1;
        step(3);
        chk("resume_edge3", 32'(count), 300);
        step(1);
        chk("resume_edge4", 32'(count), 301);

        // inc in the rollover cycle goes to shadow only.
        pulse(1'b1, 1'b0, 27);
        chk("shadow_496", 32'(u_dut.shadow_q), 496);
        chk("duty_still_48", 32'(duty), 48);
        wait_count(1023, "reach_1023_b");
        step(3);
        inc = 1'b1;
        step(1);
        inc = 1'b0;
        chk("wrap_b", 32'(wrap), 1);
        chk("duty_load_496", 32'(duty), 496);
        chk("shadow_512", 32'(u_dut.shadow_q), 512);
        chk("pending_after_wrap_inc", 32'(duty_pending), 1);
        wait_count(1023, "reach_1023_c");
        wait_wrap("wrap_c");
        chk("duty_load_512", 32'(duty), 512);

        // Reset mid-period takes priority over inc.
        wait_count(700, "reach_700");
        reset = 1'b1; inc = 1'b1;
        step(1);
        reset = 1'b0; inc = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_duty", 32'(duty), 0);
        chk("midrst_shadow", 32'(u_dut.shadow_q), 0);
        chk("midrst_prescaler", 32'(u_dut.u_prescaler.ps_q), 0);
        chk("midrst_wrap", 32'(wrap), 0);
        chk("midrst_pending", 32'(duty_pending), 0);
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1);
            if (wrap !== 1'b0) bad++;
            if (i == 3) chk("postrst_edge3", 32'(count), 0);
            if (i == 4) chk("postrst_edge4", 32'(count), 1);
        end
        chk("postrst_no_wrap", 32'(bad), 0);

        // PRESCALE=1 instance.
        f_en = 1'b1;
        step(1);
        f_reset = 1'b0;
        bad = 0;
        for (int i = 1; i <= 2048; i++) begin
            step(1);
            if (i == 1)    chk("fast_edge1", 32'(f_count), 1);
            if (i == 1023) chk("fast_edge1023", 32'(f_count), 1023);
            if (i == 1024) begin
                chk("fast_edge1024", 32'(f_count), 0);
                chk("fast_wrap1024", 32'(f_wrap), 1);
            end else if (i == 2048) begin
                chk("fast_wrap2048", 32'(f_wrap), 1);
            end else if (f_wrap !== 1'b0) begin
                bad++;
            end
        end
        chk("fast_no_stray_wrap", 32'(bad), 0);

        // Saturation with STEP=10.
        f_en = 1'b0;
        f_pulse(1'b1, 1'b0, 102);
        chk("sat_1020", 32'(u_fast.shadow_q), 1020);
        f_pulse(1'b1, 1'b0, 1);
        chk("sat_inc_1023", 32'(u_fast.shadow_q), 1023);
        f_pulse(1'b0, 1'b1, 1);
        chk("dec_from_1023", 32'(u_fast.shadow_q), 1013);
        f_reset = 1'b1;
        step(1);
        f_reset = 1'b0;
        f_pulse(1'b1, 1'b0, 1);
        chk("shadow_10", 32'(u_fast.shadow_q), 10);
        f_pulse(1'b0, 1'b1, 1);
        chk("dec_10_to_0", 32'(u_fast.shadow_q), 0);
        f_pulse(1'b0, 1'b1, 1);
        chk("dec_0_clamp", 32'(u_fast.shadow_q), 0);
        f_pulse(1'b1, 1'b0, 50);
        chk("shadow_500", 32'(u_fast.shadow_q), 500);
        f_pulse(1'b1, 1'b1, 1);
        chk("inc_dec_same_cycle", 32'(u_fast.shadow_q), 500);
        chk("fast_duty_held_en0", 32'(f_duty), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
